// File: rtl/filt_ppi_mc_if.sv
// Sample/result bus of the multi-channel polyphase interpolator.
// The sender side drives samples in and takes tagged results out.
interface filt_ppi_mc_if #(
  parameter int DW  = 16,
  parameter int OW  = 24,
  parameter int CHW = 1,
  parameter int PHW = 2
) ();
  logic                  i_valid;
  logic                  o_ready;
  logic [CHW-1:0]        i_chan;
  logic signed [DW-1:0]  i_data;
  logic                  o_valid;
  logic [CHW-1:0]        o_chan;
  logic [PHW-1:0]        o_phase;
  logic signed [OW-1:0]  o_data;

  modport master (
    output i_valid, i_chan, i_data,
    input  o_ready, o_valid, o_chan, o_phase, o_data
  );

  modport slave (
    input  i_valid, i_chan, i_data,
    output o_ready, o_valid, o_chan, o_phase, o_data
  );
endinterface

// File: rtl/filt_ppi_mc.sv
// Multi-channel polyphase interpolation FIR with one time-shared MAC for all channels/phases.
// Define FILT_PPI_MC_ROUND_EN for round-half-up before the output shift (default: floor).
module filt_ppi_mc #(
  parameter int gp_idata_width          = 16,
  parameter int gp_nchannels            = 2,
  parameter int gp_interpolation_factor = 4,
  parameter int gp_coeff_length         = 16,
  parameter int gp_coeff_width          = 16,
  parameter logic [gp_coeff_length*gp_coeff_width-1:0] gp_coeffs = '0,
  parameter int gp_comm_ccw             = 0,
  parameter int gp_out_shift            = 0,
  parameter int gp_odata_width          = 24
) (
  input  logic          i_clk,
  input  logic          i_rst_an,
  input  logic          i_ena,
  filt_ppi_mc_if.slave  bus
);

  localparam int L   = gp_interpolation_factor;
  localparam int N   = gp_coeff_length;
  localparam int K   = N / L;
  localparam int DW  = gp_idata_width;
  localparam int CW  = gp_coeff_width;
  localparam int OW  = gp_odata_width;
  localparam int CHW = (gp_nchannels > 1) ? $clog2(gp_nchannels) : 1;
  localparam int PHW = (L > 1) ? $clog2(L) : 1;
  localparam int KW  = (K > 1) ? $clog2(K) : 1;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int PW  = DW + CW;
  localparam int AW  = PW + $clog2(K) + 1;
  // Extended width leaves headroom for the rounding add and for an output wider than acc.
  localparam int EW  = ((AW + 1 > OW) ? AW + 1 : OW) + 1;
  localparam int SH1 = (gp_out_shift > 0) ? gp_out_shift - 1 : 0;

  localparam logic [PHW-1:0] P_FIRST = (gp_comm_ccw != 0) ? PHW'(L - 1) : '0;
  localparam logic [PHW-1:0] P_LAST  = (gp_comm_ccw != 0) ? '0 : PHW'(L - 1);
  localparam logic [KW-1:0]  K_LAST  = KW'(K - 1);

`ifdef FILT_PPI_MC_ROUND_EN
  localparam logic signed [EW-1:0] RND = (gp_out_shift > 0) ? (EW'(1) <<< SH1) : '0;
`else
  localparam logic signed [EW-1:0] RND = '0;
`endif

  localparam logic signed [EW-1:0] SAT_MAX = {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN = {{(EW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic {S_IDLE, S_MAC} state_t;

  state_t                 state, state_nxt;
  logic [KW-1:0]          tap;
  logic [PHW-1:0]         phase;
  logic [CHW-1:0]         chan_cur;
  logic signed [AW-1:0]   acc;
  logic signed [DW-1:0]   dline [gp_nchannels][K];

  logic signed [CW-1:0]   h_tab [N];
  logic [IW-1:0]          coef_idx;
  logic signed [CW-1:0]   coef;
  logic signed [DW-1:0]   x_cur;
  logic signed [PW-1:0]   prod;
  logic signed [AW-1:0]   sum;
  logic signed [EW-1:0]   rounded;
  logic signed [EW-1:0]   shifted;
  logic signed [OW-1:0]   sat_val;

  logic accept, chan_ok, start, last_tap, last_phase;

  for (genvar i = 0; i < N; i++) begin : g_coef
    assign h_tab[i] = gp_coeffs[i*CW +: CW];
  end

  assign accept     = i_ena & bus.i_valid & bus.o_ready;
  assign chan_ok    = int'(bus.i_chan) < gp_nchannels;
  assign start      = accept & chan_ok;
  assign last_tap   = (tap == K_LAST);
  assign last_phase = (phase == P_LAST);

  // Phase p, tap k uses prototype coefficient h[k*L+p] against the k-th newest sample.
  assign coef_idx = IW'(tap) * IW'(L) + IW'(phase);
  assign coef     = h_tab[coef_idx];
  assign x_cur    = dline[chan_cur][tap];
  assign prod     = x_cur * coef;
  assign sum      = acc + AW'(prod);

  always_comb begin
    rounded = EW'(sum) + RND;
    shifted = rounded >>> gp_out_shift;
    sat_val = shifted[OW-1:0];
    if (shifted > SAT_MAX) begin
      sat_val = SAT_MAX[OW-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_val = SAT_MIN[OW-1:0];
    end
  end

  // NOTE: state flops use non-blocking assignments so every process sees pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: default first so no path through a combinational block leaves it unassigned (latch).
    state_nxt = state;
    if (i_ena) begin
      unique case (state)
        S_IDLE: if (start) state_nxt = S_MAC;
        S_MAC:  if (last_tap && last_phase) state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.o_ready = (state == S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_an) begin
    if (!i_rst_an) begin
      tap          <= '0;
      phase        <= '0;
      chan_cur     <= '0;
      acc          <= '0;
      bus.o_valid  <= 1'b0;
      bus.o_data   <= '0;
      bus.o_chan   <= '0;
      bus.o_phase  <= '0;
      // NOTE: delay lines are reset as well, so a restart never replays stale history.
      for (int c = 0; c < gp_nchannels; c++) begin
        for (int k = 0; k < K; k++) begin
          dline[c][k] <= '0;
        end
      end
    end else if (i_ena) begin
      bus.o_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            for (int k = K - 1; k > 0; k--) begin
              dline[bus.i_chan][k] <= dline[bus.i_chan][k-1];
            end
            dline[bus.i_chan][0] <= bus.i_data;
            chan_cur <= bus.i_chan;
            tap      <= '0;
            phase    <= P_FIRST;
            acc      <= '0;
          end
        end
        S_MAC: begin
          if (last_tap) begin
            bus.o_valid <= 1'b1;
            bus.o_data  <= sat_val;
            bus.o_chan  <= chan_cur;
            bus.o_phase <= phase;
            acc         <= '0;
            tap         <= '0;
            phase       <= (gp_comm_ccw != 0) ? phase - 1'b1 : phase + 1'b1;
          end else begin
            acc <= sum;
            tap <= tap + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_filt_ppi_mc.sv
// Bench for filt_ppi_mc: two configurations driven in lockstep, checked against a
// sum-of-products reference model of the polyphase interpolator.
module tb_filt_ppi_mc;

  localparam int DW   = 16;
  localparam int NCH  = 3;
  localparam int CHW  = 2;
  localparam int L    = 4;
  localparam int PHW  = 2;
  localparam int NTAP = 16;
  localparam int K    = NTAP / L;
  localparam int CW   = 16;
  localparam int OWA  = 24;
  localparam int OWB  = 16;

`ifdef FILT_PPI_MC_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif

  // Instance A: h[i]=i+1, no shift, clockwise. Instance B: signed taps, shift 1, ccw, 16-bit out.
  function automatic int h_a(input int i);
    return i + 1;
  endfunction

  function automatic int h_b(input int i);
    return (i % 2 != 0) ? -3 * (i + 1) : 3 * (i + 1);
  endfunction

  function automatic logic [NTAP*CW-1:0] pack_coeffs(input bit sel_b);
    logic [NTAP*CW-1:0] v;
    v = '0;
    for (int i = 0; i < NTAP; i++) begin
      v[i*CW +: CW] = sel_b ? CW'(h_b(i)) : CW'(h_a(i));
    end
    return v;
  endfunction

  localparam logic [NTAP*CW-1:0] COEF_A = pack_coeffs(1'b0);
  localparam logic [NTAP*CW-1:0] COEF_B = pack_coeffs(1'b1);

  logic                  clk   = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  ena   = 1'b1;
  logic                  valid = 1'b0;
  logic [CHW-1:0]        chan  = '0;
  logic signed [DW-1:0]  data  = '0;

  always #5 clk = ~clk;

  filt_ppi_mc_if #(.DW(DW), .OW(OWA), .CHW(CHW), .PHW(PHW)) bus_a ();
  filt_ppi_mc_if #(.DW(DW), .OW(OWB), .CHW(CHW), .PHW(PHW)) bus_b ();

  assign bus_a.i_valid = valid;
  assign bus_a.i_chan  = chan;
  assign bus_a.i_data  = data;
  assign bus_b.i_valid = valid;
  assign bus_b.i_chan  = chan;
  assign bus_b.i_data  = data;

  filt_ppi_mc #(
    .gp_idata_width(DW), .gp_nchannels(NCH), .gp_interpolation_factor(L),
    .gp_coeff_length(NTAP), .gp_coeff_width(CW), .gp_coeffs(COEF_A),
    .gp_comm_ccw(0), .gp_out_shift(0), .gp_odata_width(OWA)
  ) dut_a (.i_clk(clk), .i_rst_an(rst_n), .i_ena(ena), .bus(bus_a.slave));

  filt_ppi_mc #(
    .gp_idata_width(DW), .gp_nchannels(NCH), .gp_interpolation_factor(L),
    .gp_coeff_length(NTAP), .gp_coeff_width(CW), .gp_coeffs(COEF_B),
    .gp_comm_ccw(1), .gp_out_shift(1), .gp_odata_width(OWB)
  ) dut_b (.i_clk(clk), .i_rst_an(rst_n), .i_ena(ena), .bus(bus_b.slave));

  typedef struct {
    int     chan;
    int     phase;
    longint data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   hist [NCH][K];
  int   n_cmp;
  int   n_err;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic longint sat(input longint v, input int ow);
    longint mx, mn;
    mx = (longint'(1) <<< (ow - 1)) - 1;
    mn = -mx - 1;
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      for (int k = 0; k < K; k++) hist[c][k] = 0;
    end
    qa.delete();
    qb.delete();
  endtask

  // Each accepted sample yields L outputs: y_p = sum_k h[k*L+p] * x[k], x[0] newest.
  task automatic model_accept(input int c, input int d);
    longint ya, yb;
    int pa, pb;
    if (c >= NCH) return;
    for (int k = K - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
    hist[c][0] = d;
    for (int j = 0; j < L; j++) begin
      pa = j;
      pb = L - 1 - j;
      ya = 0;
      yb = 0;
      for (int k = 0; k < K; k++) begin
        ya += longint'(h_a(k*L + pa)) * longint'(hist[c][k]);
        yb += longint'(h_b(k*L + pb)) * longint'(hist[c][k]);
      end
      yb = ROUND ? ((yb + 1) >>> 1) : (yb >>> 1);
      qa.push_back('{chan: c, phase: pa, data: sat(ya, OWA)});
      qb.push_back('{chan: c, phase: pb, data: sat(yb, OWB)});
    end
  endtask

  task automatic observe();
    exp_t e;
    if (bus_a.o_valid) begin
      check("a_strobe_expected", qa.size() != 0, 1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        check("a_data", bus_a.o_data, e.data);
        check("a_chan", bus_a.o_chan, e.chan);
        check("a_phase", bus_a.o_phase, e.phase);
      end
    end
    if (bus_b.o_valid) begin
      check("b_strobe_expected", qb.size() != 0, 1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        check("b_data", bus_b.o_data, e.data);
        check("b_chan", bus_b.o_chan, e.chan);
        check("b_phase", bus_b.o_phase, e.phase);
      end
    end
  endtask

  // Advance to the next falling edge; score strobes produced by an enabled rising edge.
  task automatic tick();
    bit en_used;
    en_used = ena;
    @(negedge clk);
    if (en_used && rst_n) observe();
  endtask

  task automatic send(input int c, input int d);
    int waited = 0;
    valid = 1'b1;
    chan  = CHW'(c);
    data  = DW'(d);
    while (!bus_a.o_ready && waited < 200) begin
      tick();
      waited++;
    end
    check("send_ready", bus_a.o_ready, 1);
    model_accept(c, d);
    tick();
    valid = 1'b0;
  endtask

  // Called right after an accept: exact o_ready / o_valid cycle pattern.
  task automatic timing();
    check("ready_low_e0", bus_a.o_ready, 0);
    for (int e = 1; e <= L*K; e++) begin
      tick();
      check("ready_t", bus_a.o_ready, e == L*K);
      check("a_valid_t", bus_a.o_valid, e % K == 0);
      check("b_valid_t", bus_b.o_valid, e % K == 0);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((!bus_a.o_ready || qa.size() != 0 || qb.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    check("drain_done", n < 300, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_at[$];
    bit took;
    logic signed [OWA-1:0] hold;

    n_cmp = 0;
    n_err = 0;
    model_reset();

    repeat (2) @(negedge clk);
    check("rst_a_ready", bus_a.o_ready, 1);
    check("rst_a_valid", bus_a.o_valid, 0);
    check("rst_a_data", bus_a.o_data, 0);
    check("rst_a_chan", bus_a.o_chan, 0);
    check("rst_a_phase", bus_a.o_phase, 0);
    check("rst_b_ready", bus_b.o_ready, 1);
    check("rst_b_valid", bus_b.o_valid, 0);
    rst_n = 1'b1;
    tick();

    // Impulse on ch0
    send(0, 1);
    repeat (K) tick();
    check("a_first_data", bus_a.o_data, 1);
    check("b_first_phase", bus_b.o_phase, 3);
    repeat (L*K - K) tick();
    check("a_last_data", bus_a.o_data, 4);
    check("b_phase0_phase", bus_b.o_phase, 0);
    check("b_round_data", bus_b.o_data, ROUND ? 2 : 1);
    for (int i = 0; i < 3; i++) begin
      send(0, 0);
      timing();
    end
    check("a_impulse_tail", bus_a.o_data, 16);
    drain();

    // Channel isolation
    send(1, 100);
    timing();
    for (int i = 0; i < 3; i++) begin
      send(0, 0);
      send(1, 0);
    end
    drain();
    check("a_iso_last", bus_a.o_data, 1600);
    check("a_iso_chan", bus_a.o_chan, 1);

    // Out-of-range channel: handshake only
    send(3, 12345);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("oor_ready", bus_a.o_ready, 1);
      check("oor_valid", bus_a.o_valid, 0);
    end

    // Saturation
    repeat (6) send(0, 32767);
    drain();
    check("b_sat_pos", bus_b.o_data, 32767);
    repeat (6) send(0, -32768);
    drain();
    check("b_sat_neg", bus_b.o_data, -32768);

    // Backpressure: valid held for 40 cycles
    valid = 1'b1;
    chan  = '0;
    data  = DW'($urandom);
    for (int i = 0; i < 40; i++) begin
      took = bus_a.o_ready;
      if (took) begin
        acc_at.push_back(i);
        model_accept(int'(chan), int'(data));
      end
      tick();
      if (took) begin
        data = DW'($urandom);
        chan = CHW'($urandom_range(0, 1));
      end
    end
    valid = 1'b0;
    check("bp_count", acc_at.size(), 3);
    if (acc_at.size() == 3) begin
      check("bp_acc0", acc_at[0], 0);
      check("bp_acc1", acc_at[1], 17);
      check("bp_acc2", acc_at[2], 34);
    end
    drain();

    // Clock-enable freeze with a pending strobe
    send(1, int'($urandom_range(0, 65535)) - 32768);
    repeat (K) tick();
    check("freeze_pre_valid", bus_a.o_valid, 1);
    hold = bus_a.o_data;
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("freeze_valid", bus_a.o_valid, 1);
      check("freeze_data", bus_a.o_data, hold);
      check("freeze_ready", bus_a.o_ready, 0);
    end
    ena = 1'b1;
    drain();

    // Random traffic, including out-of-range channels
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      send(int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)) - 32768);
    end
    drain();

    // Reset in the middle of a transaction
    send(0, 7);
    repeat (6) tick();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", bus_a.o_ready, 1);
    check("mid_rst_valid", bus_a.o_valid, 0);
    check("mid_rst_data", bus_a.o_data, 0);
    check("mid_rst_b_data", bus_b.o_data, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send(0, 1);
    drain();
    check("post_rst_last", bus_a.o_data, 4);

    check("a_leftover", qa.size(), 0);
    check("b_leftover", qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
